fifosc_arbiter: RTL and testbench

//  Shares one single-clock FIFO (depth 7, no reset of its own) among NUM_REQ producers and one consumer.
//  - Write side: round-robin valid/grant arbitration.
//  - Read side: consumer read requests, returned as a valid-qualified data beat.
//  - Sequences FIFO flush at reset and on request, and tracks occupancy itself.
//  - Issues only operations the FIFO honours; the FIFO drops insert+remove when empty or full.

---
 rtl/fifosc_arbiter.sv | 154 +++++++++++++++
 tb/tb_fifosc_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifosc_arbiter.sv
// Round-robin write arbiter and read sequencer sharing one external single-clock FIFO.
// Occupancy is tracked locally so only operations the FIFO will honour are ever issued.
module fifosc_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 7,
    parameter int LVL_W      = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic                          rd_req_i,
    output logic                          rd_ack_o,
    output logic                          rd_valid_o,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    input  logic                          flush_req_i,
    output logic                          busy_o,
    output logic [LVL_W-1:0]              level_o,
    output logic                          fifo_flush_o,
    output logic                          fifo_insert_o,
    output logic                          fifo_remove_o,
    output logic [DATA_WIDTH-1:0]         fifo_di_o,
    input  logic [DATA_WIDTH-1:0]         fifo_do_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_L  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t                state_q, state_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [PTR_W-1:0]      rrPtr_q, rrPtr_d;
    logic                  flush_q, flush_d;
    logic                  insert_q, insert_d;
    logic                  remove_q, remove_d;
    logic                  rdValid_q;
    logic [DATA_WIDTH-1:0] di_q, di_d;

    logic                  running;
    logic                  writeOk;
    logic                  readOk;
    logic                  writeAcc;
    logic                  readAcc;
    logic [NUM_REQ-1:0]    gnt;
    logic [PTR_W-1:0]      winIdx;
    logic [DATA_WIDTH-1:0] winData;
    logic                  found;
    logic [PTR_W:0]        pos;

    // A pending flush request suppresses both sides in the same cycle.
    assign running  = (state_q == ST_RUN) && !flush_req_i;
    assign writeOk  = running && (level_q < DEPTH_L);
    assign readOk   = running && (level_q != '0);
    assign readAcc  = readOk && rd_req_i;
    assign writeAcc = |gnt;

    always_comb begin
        gnt    = '0;
        winIdx = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rrPtr_q} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_REQ)) begin
                pos = pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && writeOk && req_i[pos[PTR_W-1:0]]) begin
                found               = 1'b1;
                winIdx              = pos[PTR_W-1:0];
                gnt[pos[PTR_W-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        winData = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt[j]) begin
                winData = req_data_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        level_d  = level_q;
        rrPtr_d  = rrPtr_q;
        insert_d = writeAcc;
        remove_d = readAcc;
        di_d     = di_q;
        case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN: begin
                if (flush_req_i) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b1;
                    level_d = '0;
                end else begin
                    level_d = level_q + LVL_W'(writeAcc) - LVL_W'(readAcc);
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
        if (writeAcc) begin
            rrPtr_d = (winIdx == LAST_L) ? '0 : winIdx + PTR_W'(1);
            di_d    = winData;
        end
    end

    // Reset lands in INIT with the flush strobe already raised for the following cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_INIT;
            level_q   <= '0;
            rrPtr_q   <= '0;
            flush_q   <= 1'b1;
            insert_q  <= 1'b0;
            remove_q  <= 1'b0;
            rdValid_q <= 1'b0;
            di_q      <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            rrPtr_q   <= rrPtr_d;
            flush_q   <= flush_d;
            insert_q  <= insert_d;
            remove_q  <= remove_d;
            rdValid_q <= remove_q;
            di_q      <= di_d;
        end
    end

    assign gnt_o         = gnt;
    assign rd_ack_o      = readOk;
    assign rd_valid_o    = rdValid_q;
    assign rd_data_o     = fifo_do_i;
    assign busy_o        = (state_q != ST_RUN);
    assign level_o       = level_q;
    assign fifo_flush_o  = flush_q;
    assign fifo_insert_o = insert_q;
    assign fifo_remove_o = remove_q;
    assign fifo_di_o     = di_q;

endmodule

// File: tb/tb_fifosc_arbiter.sv
// Bench for fifosc_arbiter: a behavioural FIFO, a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fifosc_arbiter;

    localparam int DW    = 4;
    localparam int NREQ  = 4;
    localparam int DEPTH = 7;

    logic              clk = 1'b0;
    logic              rstN;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] reqData;
    logic [NREQ-1:0]   gnt;
    logic              rdReq;
    logic              rdAck;
    logic              rdValid;
    logic [DW-1:0]     rdData;
    logic              flushReq;
    logic              busy;
    logic [2:0]        level;
    logic              fifoFlush;
    logic              fifoInsert;
    logic              fifoRemove;
    logic [DW-1:0]     fifoDi;
    logic [DW-1:0]     fifoDo = '0;

    int assertCount = 0;
    int failCount   = 0;

    fifosc_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NREQ), .FIFO_DEPTH(DEPTH), .LVL_W(3)) dut (
        .clk_i(clk), .rst_n_i(rstN), .req_i(req), .req_data_i(reqData), .gnt_o(gnt),
        .rd_req_i(rdReq), .rd_ack_o(rdAck), .rd_valid_o(rdValid), .rd_data_o(rdData),
        .flush_req_i(flushReq), .busy_o(busy), .level_o(level),
        .fifo_flush_o(fifoFlush), .fifo_insert_o(fifoInsert), .fifo_remove_o(fifoRemove),
        .fifo_di_o(fifoDi), .fifo_do_i(fifoDo)
    );

    always #5 clk = ~clk;

    // Attached FIFO: registered output, drops insert+remove when empty or full.
    logic [DW-1:0] fq[$];
    always @(posedge clk) begin
        if (fifoFlush) begin
            fq.delete();
        end else if (fifoInsert && fifoRemove && (fq.size() == 0 || fq.size() == DEPTH)) begin
        end else begin
            if (fifoRemove && fq.size() > 0) fifoDo <= fq.pop_front();
            if (fifoInsert && fq.size() < DEPTH) fq.push_back(fifoDi);
        end
    end

    typedef enum {M_INIT, M_RUN, M_FLUSH} mode_t;
    mode_t         mMode = M_INIT;
    logic [DW-1:0] dataQ[$];
    int            mRr = 0;
    logic          mIns = 0, mRem = 0, mValid = 0, mFlush = 0;
    logic [DW-1:0] mDi = '0, mRemData = '0, mRdData = '0;
    bit            started = 0;

    function automatic logic [NREQ-1:0] expGnt();
        if (mMode != M_RUN || flushReq || dataQ.size() >= DEPTH) return '0;
        for (int k = 0; k < NREQ; k++) begin
            int i = (mRr + k) % NREQ;
            if (req[i]) return NREQ'(1 << i);
        end
        return '0;
    endfunction

    function automatic logic expAck();
        return (mMode == M_RUN) && !flushReq && (dataQ.size() > 0);
    endfunction

    // Reference model advanced on each active edge.
    always @(posedge clk) begin
        logic [NREQ-1:0] g;
        logic            a;
        started = 1;
        if (!rstN) begin
            mMode = M_INIT; dataQ.delete(); mRr = 0;
            mIns = 0; mRem = 0; mValid = 0; mDi = '0; mFlush = 1;
        end else begin
            g = expGnt();
            a = expAck() && rdReq;
            mValid  = mRem;
            mRdData = mRemData;
            mIns    = |g;
            mRem    = a;
            if (a) mRemData = dataQ.pop_front();
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    mDi = reqData[i*DW +: DW];
                    dataQ.push_back(mDi);
                    mRr = (i + 1) % NREQ;
                end
            end
            mFlush = 0;
            case (mMode)
                M_INIT:  mMode = M_RUN;
                M_RUN:   if (flushReq) begin mMode = M_FLUSH; mFlush = 1; dataQ.delete(); end
                default: mMode = M_RUN;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            checkOutput("gnt", 32'(gnt), 32'(expGnt()));
            checkOutput("rd_ack", 32'(rdAck), 32'(expAck()));
            checkOutput("busy", 32'(busy), 32'(mMode != M_RUN));
            checkOutput("level", 32'(level), 32'(dataQ.size()));
            checkOutput("fifo_flush", 32'(fifoFlush), 32'(mFlush));
            checkOutput("fifo_insert", 32'(fifoInsert), 32'(mIns));
            checkOutput("fifo_remove", 32'(fifoRemove), 32'(mRem));
            checkOutput("fifo_di", 32'(fifoDi), 32'(mDi));
            checkOutput("rd_valid", 32'(rdValid), 32'(mValid));
            if (mValid) checkOutput("rd_data", 32'(rdData), 32'(mRdData));
        end
    end

    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] q, input logic [NREQ*DW-1:0] d,
                                 input logic rd, input logic fl);
        @(posedge clk);
        #1;
        rstN = r; req = q; reqData = d; rdReq = rd; flushReq = fl;
    endtask

    int grantSeq[7] = '{0, 1, 2, 3, 0, 1, 2};

    initial begin
        int wrBias;
        rstN = 0; req = 4'b1111; reqData = 16'h4321; rdReq = 0; flushReq = 0;
        applyStimulus(0, 4'b1111, 16'h4321, 0, 0);
        applyStimulus(1, 4'b1111, 16'h4321, 0, 0);
        @(negedge clk);
        checkOutput("init busy", 32'(busy), 1);
        checkOutput("init fifo_flush", 32'(fifoFlush), 1);
        checkOutput("init level", 32'(level), 0);
        checkOutput("init gnt", 32'(gnt), 0);

        for (int g = 0; g < 7; g++) begin
            applyStimulus(1, 4'b1111, 16'h4321, 0, 0);
            @(negedge clk);
            checkOutput("rr gnt", 32'(gnt), 32'(1 << grantSeq[g]));
        end

        applyStimulus(1, 4'b0010, 16'h4321, 1, 0);
        @(negedge clk);
        checkOutput("full gnt", 32'(gnt), 0);
        checkOutput("full rd_ack", 32'(rdAck), 1);
        checkOutput("full level", 32'(level), 7);
        applyStimulus(1, 4'b0010, 16'h4321, 0, 0);
        @(negedge clk);
        checkOutput("refill gnt", 32'(gnt), 32'b0010);
        applyStimulus(1, 4'b0000, 16'h4321, 0, 0);
        @(negedge clk);
        checkOutput("refill level", 32'(level), 7);

        repeat (3) applyStimulus(1, 4'b0000, 16'h4321, 1, 0);
        applyStimulus(1, 4'b1111, 16'h4321, 1, 1);
        @(negedge clk);
        checkOutput("flush gnt", 32'(gnt), 0);
        checkOutput("flush rd_ack", 32'(rdAck), 0);
        checkOutput("pre-flush level", 32'(level), 4);
        applyStimulus(1, 4'b0000, 16'h4321, 1, 0);
        @(negedge clk);
        checkOutput("flush pulse", 32'(fifoFlush), 1);
        checkOutput("flush level", 32'(level), 0);
        applyStimulus(1, 4'b0000, 16'h4321, 1, 0);
        @(negedge clk);
        checkOutput("post-flush rd_ack", 32'(rdAck), 0);
        checkOutput("post-flush fifo_flush", 32'(fifoFlush), 0);

        applyStimulus(1, 4'b0001, 16'h050A, 1, 0);
        @(negedge clk);
        checkOutput("empty rd_ack", 32'(rdAck), 0);
        applyStimulus(1, 4'b0100, 16'h050A, 0, 0);
        applyStimulus(1, 4'b0000, 16'h050A, 1, 0);
        applyStimulus(1, 4'b0000, 16'h050A, 1, 0);
        applyStimulus(1, 4'b0000, 16'h050A, 0, 0);
        @(negedge clk);
        checkOutput("data first valid", 32'(rdValid), 1);
        checkOutput("data first", 32'(rdData), 32'hA);
        applyStimulus(1, 4'b0000, 16'h050A, 0, 0);
        @(negedge clk);
        checkOutput("data second valid", 32'(rdValid), 1);
        checkOutput("data second", 32'(rdData), 32'h5);

        repeat (3) applyStimulus(1, 4'b0001, 16'h050A, 0, 0);
        applyStimulus(1, 4'b0010, 16'h050A, 1, 0);
        @(negedge clk);
        checkOutput("simul level", 32'(level), 3);
        checkOutput("simul gnt", 32'(gnt), 32'b0010);
        checkOutput("simul rd_ack", 32'(rdAck), 1);
        applyStimulus(1, 4'b0000, 16'h050A, 0, 0);
        @(negedge clk);
        checkOutput("simul insert", 32'(fifoInsert), 1);
        checkOutput("simul remove", 32'(fifoRemove), 1);
        checkOutput("simul level after", 32'(level), 3);

        wrBias = 5;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) wrBias = $urandom_range(1, 9);
            applyStimulus(($urandom_range(0, 399) != 0),
                          ($urandom_range(0, 9) < wrBias) ? NREQ'($urandom) : '0,
                          (NREQ*DW)'($urandom),
                          ($urandom_range(0, 9) >= wrBias),
                          ($urandom_range(0, 59) == 0));
        end
        applyStimulus(1, 4'b0000, 16'h0000, 0, 0);
        repeat (4) applyStimulus(1, 4'b0000, 16'h0000, 0, 0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
